// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - frame sequencer for sample load, transform run, pipeline drain and bin unload
module fft_sequencer #(
    parameter int FFT_SIZE    = 512,
    parameter int LEVEL       = 9,
    parameter int RUN_TIMEOUT = 8192
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_req,
    input  logic             abort,
    input  logic             smp_valid,
    output logic             smp_ready,
    output logic             ld_we,
    output logic [LEVEL-1:0] ld_addr,
    output logic             fft_load,
    output logic             fft_start,
    output logic             bf_enable,
    input  logic             fft_done,
    output logic [LEVEL-1:0] rd_addr,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             err_timeout
);
    localparam int RW = (RUN_TIMEOUT > 2) ? $clog2(RUN_TIMEOUT) : 1;
    localparam logic [LEVEL-1:0] LD_LAST  = LEVEL'(FFT_SIZE - 1);
    localparam logic [LEVEL-1:0] RD_LAST  = LEVEL'(FFT_SIZE / 2 - 1);
    localparam logic [RW-1:0]    RUN_LAST = RW'(RUN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_RUN, S_DRAIN, S_UNLOAD
    } state_t;

    state_t           state_q, state_d;
    logic [LEVEL-1:0] ld_addr_q, rd_addr_q;
    logic [RW-1:0]    run_cnt_q;
    logic             drain_q;
    logic             smp_ready_q, fft_load_q, fft_start_q, bf_enable_q;
    logic             rd_valid_q, busy_q, frame_done_q, err_timeout_q;

    logic ld_accept, rd_accept, load_last, unload_last, run_expired;

    assign ld_accept   = (state_q == S_LOAD) && smp_valid;
    assign rd_accept   = (state_q == S_UNLOAD) && rd_ready;
    assign load_last   = ld_accept && (ld_addr_q == LD_LAST);
    assign unload_last = rd_accept && (rd_addr_q == RD_LAST);
    assign run_expired = (state_q == S_RUN) && !fft_done && (run_cnt_q == RUN_LAST);

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (frame_req) state_d = S_LOAD;
                S_LOAD:   if (load_last) state_d = S_ARM;
                S_ARM:    state_d = S_RUN;
                S_RUN: begin
                    if (fft_done)         state_d = S_DRAIN;
                    else if (run_expired) state_d = S_IDLE;
                end
                S_DRAIN:  if (drain_q) state_d = S_UNLOAD;
                S_UNLOAD: if (unload_last) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Strobes are registered from the next state so they change together with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ld_addr_q     <= '0;
            rd_addr_q     <= '0;
            run_cnt_q     <= '0;
            drain_q       <= 1'b0;
            smp_ready_q   <= 1'b0;
            fft_load_q    <= 1'b0;
            fft_start_q   <= 1'b0;
            bf_enable_q   <= 1'b0;
            rd_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            smp_ready_q  <= (state_d == S_LOAD);
            fft_load_q   <= (state_d == S_LOAD);
            fft_start_q  <= (state_d == S_ARM) || (state_d == S_RUN);
            bf_enable_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
            rd_valid_q   <= (state_d == S_UNLOAD);
            busy_q       <= (state_d != S_IDLE);
            frame_done_q <= !abort && unload_last;
            run_cnt_q    <= (state_q == S_RUN && state_d == S_RUN) ? run_cnt_q + RW'(1) : '0;
            drain_q      <= (state_q == S_DRAIN) && (state_d == S_DRAIN);
            if (!abort) begin
                if (state_q == S_IDLE && frame_req) begin
                    ld_addr_q     <= '0;
                    err_timeout_q <= 1'b0;
                end
                // The final load address is held so ARM still presents FFT_SIZE-1.
                if (ld_accept && !load_last) ld_addr_q <= ld_addr_q + LEVEL'(1);
                if (run_expired) err_timeout_q <= 1'b1;
                if (rd_accept) rd_addr_q <= unload_last ? '0 : rd_addr_q + LEVEL'(1);
            end else begin
                rd_addr_q <= '0;
            end
        end
    end

    assign smp_ready   = smp_ready_q;
    assign ld_we       = smp_valid && (state_q == S_LOAD);
    assign ld_addr     = ld_addr_q;
    assign fft_load    = fft_load_q;
    assign fft_start   = fft_start_q;
    assign bf_enable   = bf_enable_q;
    assign rd_addr     = rd_addr_q;
    assign rd_valid    = rd_valid_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - self-checking bench for fft_sequencer
module tb_fft_sequencer;
    localparam int N   = 512;
    localparam int L   = 9;
    localparam int TMO = 8192;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         frame_req = 1'b0, abort = 1'b0, smp_valid = 1'b0;
    logic         fft_done = 1'b0, rd_ready = 1'b0;
    logic         smp_ready, ld_we, fft_load, fft_start, bf_enable;
    logic         rd_valid, busy, frame_done, err_timeout;
    logic [L-1:0] ld_addr, rd_addr;

    fft_sequencer #(.FFT_SIZE(N), .LEVEL(L), .RUN_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .frame_req(frame_req), .abort(abort),
        .smp_valid(smp_valid), .smp_ready(smp_ready), .ld_we(ld_we), .ld_addr(ld_addr),
        .fft_load(fft_load), .fft_start(fft_start), .bf_enable(bf_enable),
        .fft_done(fft_done), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    wire [8:0] out_v = {busy, smp_ready, fft_load, fft_start, bf_enable,
                        rd_valid, frame_done, err_timeout, ld_we};

    int tests = 0;
    int fails = 0;
    bit m_err = 1'b0;
    bit chained = 1'b0;

    typedef struct {
        int vpct;
        int done_at;
        int rmode;
        int abph;
        int abat;
        bit chain;
        bit exp_fd;
        bit exp_err;
    } vec_t;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    // Expected strobes per phase: 0 idle, 1 load, 2 arm, 3 run, 4 drain, 5 unload.
    function automatic logic [8:0] expv(input int ph, input bit we, input bit fd, input bit er);
        case (ph)
            0:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fd,   er, 1'b0};
            1:       return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, er, we};
            2:       return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, er, 1'b0};
            3:       return {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, er, 1'b0};
            4:       return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, er, 1'b0};
            5:       return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, er, 1'b0};
            default: return 9'h0;
        endcase
    endfunction

    task automatic cyc(input bit fr, input bit ab, input bit sv, input bit fd, input bit rr);
        @(negedge clk);
        frame_req = fr;
        abort     = ab;
        smp_valid = sv;
        fft_done  = fd;
        rd_ready  = rr;
        #1;
    endtask

    task automatic end_checks(input bit exp_fd, input bit exp_err);
        check("end_frame_done", frame_done, exp_fd);
        check("end_err_timeout", err_timeout, exp_err);
    endtask

    task automatic abort_end(input bit exp_fd, input bit exp_err);
        cyc(0, 0, 0, 0, 0);
        check("abort_out", out_v, expv(0, 0, 0, m_err));
        end_checks(exp_fd, exp_err);
    endtask

    task automatic do_frame(input int vpct, input int done_at, input int rmode,
                            input int abph, input int abat, input bit chain_in,
                            input bit chain_out, input bit exp_fd, input bit exp_err,
                            output bit chained_o);
        int idx, bin, guard, ucnt;
        bit sv, fd, rr, ab;
        chained_o = 1'b0;
        fd = 1'b0;
        if (!chain_in) begin
            cyc(1, 0, 0, 0, 0);
            check("idle_out", out_v, expv(0, 0, 0, m_err));
        end
        m_err = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < N) begin
            sv = ($urandom_range(99, 0) < vpct);
            ab = (abph == 1 && idx == abat);
            if (ab) sv = 1'b1;
            cyc(rbit(), ab, sv, 0, 0);
            check("load_out", out_v, expv(1, sv, 0, 0));
            check("ld_addr", ld_addr, idx);
            if (ab) begin
                abort_end(exp_fd, exp_err);
                return;
            end
            if (sv) idx++;
            guard++;
            if (guard > 50 * N) begin
                fail_bound("load_bound");
                return;
            end
        end
        cyc(rbit(), 0, rbit(), 0, rbit());
        check("arm_out", out_v, expv(2, 0, 0, 0));
        check("arm_ld_addr", ld_addr, N - 1);
        for (int k = 0; k < TMO; k++) begin
            fd = (k == done_at);
            ab = (abph == 2) && fd;
            cyc(rbit(), ab, 0, fd, 0);
            check("run_out", out_v, expv(3, 0, 0, 0));
            if (ab) begin
                abort_end(exp_fd, exp_err);
                return;
            end
            if (fd) break;
            if (k == TMO - 1) begin
                m_err = 1'b1;
                cyc(0, 0, 0, 0, 0);
                check("timeout_out", out_v, expv(0, 0, 0, m_err));
                end_checks(exp_fd, exp_err);
                return;
            end
        end
        for (int d = 0; d < 2; d++) begin
            cyc(rbit(), 0, 0, 0, rbit());
            check("drain_out", out_v, expv(4, 0, 0, 0));
        end
        bin = 0;
        ucnt = 0;
        guard = 0;
        while (bin < N / 2) begin
            rr = (rmode == 1) ? ucnt[0] : rbit();
            ab = (abph == 3 && bin == abat);
            if (ab) rr = 1'b1;
            cyc(rbit(), ab, 0, 0, rr);
            check("unload_out", out_v, expv(5, 0, 0, 0));
            check("rd_addr", rd_addr, bin);
            if (ab) begin
                abort_end(exp_fd, exp_err);
                return;
            end
            if (rr) bin++;
            ucnt++;
            guard++;
            if (guard > 50 * N) begin
                fail_bound("unload_bound");
                return;
            end
        end
        cyc(chain_out, 0, 0, 0, 0);
        check("done_out", out_v, expv(0, 0, 1, m_err));
        check("done_rd_addr", rd_addr, 0);
        end_checks(exp_fd, exp_err);
        if (chain_out) begin
            chained_o = 1'b1;
        end else begin
            cyc(0, 0, 0, 0, 0);
            check("done_pulse", out_v, expv(0, 0, 0, m_err));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vp, da, ap, aa;
        bit co;
        tbl[0] = '{vpct: 100, done_at: 4608, rmode: 1, abph: 0, abat: 0,   chain: 1, exp_fd: 1, exp_err: 0};
        tbl[1] = '{vpct: 60,  done_at: 20,   rmode: 0, abph: 0, abat: 0,   chain: 0, exp_fd: 1, exp_err: 0};
        tbl[2] = '{vpct: 100, done_at: -1,   rmode: 0, abph: 0, abat: 0,   chain: 0, exp_fd: 0, exp_err: 1};
        tbl[3] = '{vpct: 70,  done_at: 10,   rmode: 0, abph: 1, abat: 200, chain: 0, exp_fd: 0, exp_err: 0};
        tbl[4] = '{vpct: 80,  done_at: 50,   rmode: 0, abph: 2, abat: 0,   chain: 0, exp_fd: 0, exp_err: 0};
        tbl[5] = '{vpct: 90,  done_at: 3,    rmode: 1, abph: 3, abat: 255, chain: 0, exp_fd: 0, exp_err: 0};
        tbl[6] = '{vpct: 50,  done_at: 0,    rmode: 0, abph: 0, abat: 0,   chain: 0, exp_fd: 1, exp_err: 0};

        repeat (2) @(negedge clk);
        #1;
        check("reset_out", out_v, 9'h0);
        check("reset_ld_addr", ld_addr, 0);
        check("reset_rd_addr", rd_addr, 0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++)
            do_frame(tbl[i].vpct, tbl[i].done_at, tbl[i].rmode, tbl[i].abph, tbl[i].abat,
                     chained, tbl[i].chain, tbl[i].exp_fd, tbl[i].exp_err, chained);

        for (int i = 0; i < 4; i++) begin
            vp = $urandom_range(100, 30);
            da = $urandom_range(100, 0);
            ap = ($urandom_range(3, 0) == 0) ? $urandom_range(3, 1) : 0;
            aa = (ap == 3) ? $urandom_range(N / 2 - 1, 0) : $urandom_range(N - 1, 0);
            co = (i < 3) ? rbit() : 1'b0;
            do_frame(vp, da, $urandom_range(1, 0), ap, aa, chained, co, ap == 0, 1'b0, chained);
        end

        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
        check("pre_reset_run", out_v, expv(3, 0, 0, 0));
        #1 reset = 1'b0;
        #1;
        check("async_reset_out", out_v, 9'h0);
        check("async_reset_ld_addr", ld_addr, 0);
        check("async_reset_rd_addr", rd_addr, 0);
        #1 reset = 1'b1;
        m_err = 1'b0;
        cyc(0, 0, 0, 1, 0);
        check("post_reset_idle", out_v, expv(0, 0, 0, 0));
        cyc(0, 0, 0, 0, 0);
        check("post_reset_hold", out_v, expv(0, 0, 0, 0));
        do_frame(100, 10, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, chained);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
